// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, access size
// encodings and the byte-span helper used to build lane masks.
package ysyx_22050612_lsu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_REQ0 = 3'd1;
  localparam state_t S_RSP0 = 3'd2;
  localparam state_t S_REQ1 = 3'd3;
  localparam state_t S_RSP1 = 3'd4;
  localparam state_t S_DONE = 3'd5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Byte span of an access over two consecutive bus words (up to 8 lanes
  // each): bits [NB-1:0] are the first beat, bits [2*NB-1:NB] the second.
  function automatic logic [15:0] span_mask(input logic [2:0] off,
                                            input logic [1:0] size);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_if.sv
// Bundles the EXU-facing handshake and the data-memory bus of the LSU.
// master = the LSU itself, slave = the environment (EXU + memory).
interface ysyx_22050612_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic                in_valid;
  logic                in_ready;
  logic                in_wen;
  logic [1:0]          in_size;
  logic                in_unsigned;
  logic [ADDR_W-1:0]   in_addr;
  logic [XLEN-1:0]     in_wdata;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_rdata;
  logic                out_fault;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_wen;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [XLEN-1:0]     mem_req_wdata;
  logic [XLEN/8-1:0]   mem_req_wmask;
  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rsp_rdata;

  modport master (
    input  in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    input  out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output in_ready, out_valid, out_rdata, out_fault,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
  );

  modport slave (
    output in_valid, in_wen, in_size, in_unsigned, in_addr, in_wdata,
    output out_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  in_ready, out_valid, out_rdata, out_fault,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/ysyx_22050612_lane_align.sv
// Combinational lane alignment: byte-enable masks and positioned write data
// for up to two bus beats, and extraction plus sign/zero extension of load
// data from the concatenated beats {hi, lo}.
module ysyx_22050612_lane_align
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] i_off,
  input  logic [1:0]                i_size,
  input  logic                      i_unsigned,
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [XLEN-1:0]           i_lo,
  input  logic [XLEN-1:0]           i_hi,
  output logic [XLEN/8-1:0]         o_mask0,
  output logic [XLEN/8-1:0]         o_mask1,
  output logic [XLEN-1:0]           o_wdata0,
  output logic [XLEN-1:0]           o_wdata1,
  output logic [XLEN-1:0]           o_rdata
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [15:0]     w_span;
  logic [7:0]      w_bit_off;
  logic [7:0]      w_rsh;
  logic [XLEN-1:0] w_shr;

  // Keep the low `size` bytes and fill the rest with the sign or with zero.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] sz,
                                             input logic uns);
    int              bits;
    logic            sgn;
    logic [XLEN-1:0] r;
    bits = 8 << sz;
    if (bits > XLEN) bits = XLEN;
    sgn = ~uns & v[bits-1];
    for (int i = 0; i < XLEN; i++) r[i] = (i < bits) ? v[i] : sgn;
    return r;
  endfunction

  assign w_span    = span_mask(3'(i_off), i_size);
  assign w_bit_off = 8'({i_off, 3'b000});
  assign w_rsh     = 8'(XLEN) - w_bit_off;

  assign o_mask0  = w_span[NB-1:0];
  assign o_mask1  = w_span[2*NB-1:NB];
  assign o_wdata0 = i_wdata << w_bit_off;
  // Second beat carries the bytes that spilled past the first word.
  assign o_wdata1 = i_wdata >> w_rsh;
  assign w_shr    = XLEN'({i_hi, i_lo} >> w_bit_off);
  assign o_rdata  = extend(w_shr, i_size, i_unsigned);

  if (OFF_W > 3) begin : g_bad_xlen
    $error("XLEN larger than 64 not supported");
  end
endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: accepts one access, issues one or two aligned
// bus beats (word-crossing accesses are split or faulted) and returns the
// extended load result / store completion through a valid/ready handshake.
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int ADDR_W         = 64,
  parameter int ALLOW_MISALIGN = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_22050612_lsu_if.master bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_t            r_state;
  state_t            w_next;
  logic              r_live;
  logic              r_wen;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_cross;
  logic              r_fault;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_hi;

  logic              w_accept;
  logic [4:0]        w_end;
  logic              w_cross_in;
  logic              w_fault_in;
  logic [ADDR_W-1:0] w_base0;
  logic [ADDR_W-1:0] w_base1;
  logic [NB-1:0]     w_mask0;
  logic [NB-1:0]     w_mask1;
  logic [XLEN-1:0]   w_wdata0;
  logic [XLEN-1:0]   w_wdata1;
  logic [XLEN-1:0]   w_rdata;

  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_end      = 5'(bus.in_addr[OFF_W-1:0]) + (5'd1 << bus.in_size);
  assign w_cross_in = w_end > 5'(NB);
  assign w_fault_in = (bus.in_size > 2'(OFF_W)) | (w_cross_in & (ALLOW_MISALIGN == 0));
  assign w_base0    = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_base1    = w_base0 + ADDR_W'(NB);

  ysyx_22050612_lane_align #(.XLEN(XLEN)) u_align (
    .i_off      (r_addr[OFF_W-1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_lo       (r_lo),
    .i_hi       (r_hi),
    .o_mask0    (w_mask0),
    .o_mask1    (w_mask1),
    .o_wdata0   (w_wdata0),
    .o_wdata1   (w_wdata1),
    .o_rdata    (w_rdata)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fault_in ? S_DONE : S_REQ0;
      S_REQ0: if (bus.mem_req_ready) w_next = S_RSP0;
      S_RSP0: if (bus.mem_rsp_valid) w_next = r_cross ? S_REQ1 : S_DONE;
      S_REQ1: if (bus.mem_req_ready) w_next = S_RSP1;
      S_RSP1: if (bus.mem_rsp_valid) w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; r_live holds in_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // Request fields latched at accept, response beats captured in RSP0/RSP1.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= bus.in_wen;
      r_size  <= bus.in_size;
      r_uns   <= bus.in_unsigned;
      r_addr  <= bus.in_addr;
      r_wdata <= bus.in_wdata;
      r_cross <= w_cross_in;
      r_fault <= w_fault_in;
      r_hi    <= '0;
    end
    if (r_state == S_RSP0 && bus.mem_rsp_valid) r_lo <= bus.mem_rsp_rdata;
    if (r_state == S_RSP1 && bus.mem_rsp_valid) r_hi <= bus.mem_rsp_rdata;
  end

  // Outputs are decoded from state so they are all zero while in reset.
  always_comb begin
    bus.in_ready      = r_live & (r_state == S_IDLE);
    bus.out_valid     = (r_state == S_DONE);
    bus.out_fault     = (r_state == S_DONE) & r_fault;
    bus.out_rdata     = ((r_state == S_DONE) & ~r_fault & ~r_wen) ? w_rdata : '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_wen   = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_wmask = '0;
    if (r_state == S_REQ0) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_req_wen   = r_wen;
      bus.mem_req_addr  = w_base0;
      bus.mem_req_wdata = r_wen ? w_wdata0 : '0;
      bus.mem_req_wmask = r_wen ? w_mask0 : '1;
    end else if (r_state == S_REQ1) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_req_wen   = r_wen;
      bus.mem_req_addr  = w_base1;
      bus.mem_req_wdata = r_wen ? w_wdata1 : '0;
      bus.mem_req_wmask = r_wen ? w_mask1 : '1;
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Directed bench for the LSU: byte-level reference memory and access model,
// a bus responder, one per-cycle compare process and literal spot checks.
module tb_ysyx_22050612_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22050612_lsu_if #(.XLEN(64), .ADDR_W(64)) bus ();
  ysyx_22050612_lsu_if #(.XLEN(64), .ADDR_W(64)) nm ();

  ysyx_22050612_lsu #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  ysyx_22050612_lsu #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGN(0)) u_nm (
    .clk(clk), .rst_n(rst_n), .bus(nm));

  int total = 0;
  int bad = 0;

  logic [7:0]  mem_b [0:255];

  // expectation of the current access (written by the driver)
  int          txn_id = 0;
  logic        exp_active = 1'b0;
  int          exp_nbeats;
  logic        exp_wen;
  logic [63:0] exp_addr [2];
  logic [63:0] exp_wd [2];
  logic [7:0]  exp_mask [2];
  logic [63:0] exp_rdata;
  logic        exp_fault;

  // observed beats (written by the compare process)
  int          beat_idx = 0;
  logic [63:0] cap_addr [2];
  logic [63:0] cap_wd [2];
  logic [7:0]  cap_mask [2];

  // responder controls (written by the driver)
  int rsp_delay = 0;
  int stall_n = 0;
  int stall_start = 0;

  logic [63:0] last_rdata;
  logic        last_fault;

  task automatic chk(input string nm_s, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm_s, act, req);
    end
  endtask

  // Reference: walk the access byte by byte over the reference memory.
  task automatic model(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    int nb, k, lane;
    logic [63:0] base, a, val;
    nb = 1 << size;
    base = addr & ~64'h7;
    exp_wen = wen;
    exp_fault = 1'b0;
    exp_nbeats = ((int'(addr[2:0]) + nb) > 8) ? 2 : 1;
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = base + 64'(8 * i);
      exp_mask[i] = wen ? 8'h00 : 8'hFF;
      exp_wd[i]   = '0;
    end
    val = '0;
    for (int i = 0; i < nb; i++) begin
      a = addr + 64'(i);
      k = int'((a - base) >> 3);
      lane = int'(a[2:0]);
      if (wen) begin
        exp_mask[k][lane] = 1'b1;
        exp_wd[k][lane*8 +: 8] = wdata[i*8 +: 8];
      end else begin
        val[i*8 +: 8] = mem_b[a[7:0]];
      end
    end
    if (!wen && !uns && nb < 8 && val[nb*8-1])
      for (int j = nb * 8; j < 64; j++) val[j] = 1'b1;
    exp_rdata = wen ? 64'd0 : val;
  endtask

  // Memory responder: one response per handshaken beat, optionally delayed.
  initial begin
    logic pend;
    int pend_cnt;
    logic [63:0] pend_addr, w;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid && bus.mem_req_ready && !pend) begin
        pend = 1'b1;
        pend_cnt = rsp_delay;
        pend_addr = bus.mem_req_addr;
      end
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 64'hA5A5_5A5A_C3C3_3C3C;
      if (pend) begin
        if (pend_cnt == 0) begin
          for (int j = 0; j < 8; j++) w[j*8 +: 8] = mem_b[pend_addr[7:0] + 8'(j)];
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_rdata = w;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.mem_req_ready = !((cyc - stall_start) < stall_n);
    end
  end

  // Compare process: every cycle, check outputs against the expectation.
  initial begin
    int last_txn;
    last_txn = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_fault", 64'(bus.out_fault), 0);
        chk("rst_out_rdata", bus.out_rdata, 0);
        chk("rst_req_valid", 64'(bus.mem_req_valid), 0);
        chk("rst_req_wen", 64'(bus.mem_req_wen), 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_req_wdata", bus.mem_req_wdata, 0);
        chk("rst_req_wmask", 64'(bus.mem_req_wmask), 0);
        chk("rst_nm_in_ready", 64'(nm.in_ready), 0);
        chk("rst_nm_out_valid", 64'(nm.out_valid), 0);
      end else begin
        if (txn_id != last_txn) begin
          last_txn = txn_id;
          beat_idx = 0;
        end
        if (bus.mem_req_valid) begin
          chk("beat_expected", 64'(exp_active && beat_idx < exp_nbeats), 1);
          if (exp_active && beat_idx < exp_nbeats) begin
            chk("req_addr", bus.mem_req_addr, exp_addr[beat_idx]);
            chk("req_wmask", 64'(bus.mem_req_wmask), 64'(exp_mask[beat_idx]));
            chk("req_wdata", bus.mem_req_wdata, exp_wd[beat_idx]);
            chk("req_wen", 64'(bus.mem_req_wen), 64'(exp_wen));
            if (bus.mem_req_ready) begin
              cap_addr[beat_idx] = bus.mem_req_addr;
              cap_wd[beat_idx]   = bus.mem_req_wdata;
              cap_mask[beat_idx] = bus.mem_req_wmask;
              beat_idx++;
            end
          end
        end
        if (bus.out_valid) begin
          chk("out_expected", 64'(exp_active), 1);
          if (exp_active) begin
            chk("out_rdata", bus.out_rdata, exp_rdata);
            chk("out_fault", 64'(bus.out_fault), 64'(exp_fault));
          end
        end
        chk("nm_no_bus", 64'(nm.mem_req_valid), 0);
      end
    end
  end

  task automatic accept(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int req_stall, output int acc);
    int n;
    @(negedge clk);
    bus.in_wen = wen;
    bus.in_size = size;
    bus.in_unsigned = uns;
    bus.in_addr = addr;
    bus.in_wdata = wdata;
    bus.in_valid = 1'b1;
    stall_start = cyc;
    stall_n = req_stall;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 50), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_acc(input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input int req_stall, input int out_stall, input int exp_lat);
    int acc, n;
    model(wen, size, uns, addr, wdata);
    txn_id++;
    exp_active = 1'b1;
    bus.out_ready = 1'b0;
    accept(wen, size, uns, addr, wdata, req_stall, acc);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("out_in_time", 64'(n < 60), 1);
    if (exp_lat > 0) chk("latency", 64'(cyc - acc + 1), 64'(exp_lat));
    repeat (out_stall) @(negedge clk);
    chk("out_valid_held", 64'(bus.out_valid), 1);
    last_rdata = bus.out_rdata;
    last_fault = bus.out_fault;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("in_ready_after_done", 64'(bus.in_ready), 1);
    chk("beat_count", 64'(beat_idx), 64'(exp_nbeats));
  endtask

  initial begin
    int acc, n;
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'(i * 29 + 7);
    bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_size = 2'd0; bus.in_unsigned = 1'b0;
    bus.in_addr = '0; bus.in_wdata = '0; bus.out_ready = 1'b0;
    nm.in_valid = 1'b0; nm.in_wen = 1'b0; nm.in_size = 2'd0; nm.in_unsigned = 1'b0;
    nm.in_addr = '0; nm.in_wdata = '0; nm.out_ready = 1'b0;
    nm.mem_req_ready = 1'b1; nm.mem_rsp_valid = 1'b0; nm.mem_rsp_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(bus.in_ready), 1);
    chk("nm_in_ready_after_reset", 64'(nm.in_ready), 1);

    // aligned signed word load
    for (int i = 0; i < 4; i++) mem_b[i] = 8'h00;
    mem_b[4] = 8'hEF; mem_b[5] = 8'hBE; mem_b[6] = 8'hAD; mem_b[7] = 8'hDE;
    do_acc(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 0, 0, 3);
    chk("lit_lw_rdata", last_rdata, 64'hFFFF_FFFF_DEAD_BEEF);
    chk("lit_lw_mask", 64'(cap_mask[0]), 64'hFF);
    chk("lit_lw_addr", cap_addr[0], 64'h8000_0000);

    // store byte
    do_acc(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 0, 0, 3);
    chk("lit_sb_mask", 64'(cap_mask[0]), 64'h08);
    chk("lit_sb_wdata", cap_wd[0], 64'hAB00_0000);

    // split unsigned word load
    mem_b[6] = 8'h44; mem_b[7] = 8'h33; mem_b[8] = 8'h22; mem_b[9] = 8'h11;
    do_acc(1'b0, 2'd2, 1'b1, 64'h8000_0006, 64'd0, 0, 0, 5);
    chk("lit_split_rdata", last_rdata, 64'h0000_0000_1122_3344);
    chk("lit_split_addr0", cap_addr[0], 64'h8000_0000);
    chk("lit_split_addr1", cap_addr[1], 64'h8000_0008);

    // sign/zero extension across sizes, split stores, aligned doubleword
    do_acc(1'b0, 2'd0, 1'b0, 64'h8000_0004, 64'd0, 0, 0, 3);
    chk("lit_lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFEF);
    do_acc(1'b0, 2'd0, 1'b1, 64'h8000_0004, 64'd0, 0, 0, 3);
    do_acc(1'b0, 2'd1, 1'b0, 64'h8000_0005, 64'd0, 0, 0, 3);
    do_acc(1'b0, 2'd1, 1'b0, 64'h8000_0007, 64'd0, 0, 0, 5);
    do_acc(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 0, 0, 3);
    do_acc(1'b0, 2'd3, 1'b0, 64'h8000_0013, 64'd0, 0, 0, 5);
    do_acc(1'b1, 2'd3, 1'b0, 64'h8000_000D, 64'h0807_0605_0403_0201, 0, 0, 5);
    chk("lit_sd_mask1", 64'(cap_mask[1]), 64'h1F);
    chk("lit_sd_wdata1", cap_wd[1], 64'h0000_0008_0706_0504);
    do_acc(1'b1, 2'd1, 1'b0, 64'h8000_0026, 64'hBEEF, 0, 0, 3);
    do_acc(1'b1, 2'd2, 1'b0, 64'h8000_002E, 64'hCAFE_F00D, 0, 0, 5);

    // backpressure on both sides
    do_acc(1'b0, 2'd2, 1'b0, 64'h8000_0030, 64'd0, 4, 2, 0);

    // forbidden misalignment faults without bus traffic
    @(negedge clk);
    nm.in_wen = 1'b0; nm.in_size = 2'd2; nm.in_unsigned = 1'b1;
    nm.in_addr = 64'h8000_0006; nm.in_valid = 1'b1;
    n = 0;
    while (!nm.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 nm.in_valid = 1'b0;
    @(negedge clk);
    chk("nm_fault_valid_c1", 64'(nm.out_valid), 1);
    chk("nm_fault_flag", 64'(nm.out_fault), 1);
    chk("nm_fault_rdata", nm.out_rdata, 0);
    repeat (2) @(negedge clk);
    chk("nm_fault_held", 64'(nm.out_valid), 1);
    nm.out_ready = 1'b1;
    @(posedge clk);
    #1 nm.out_ready = 1'b0;
    @(negedge clk);
    chk("nm_in_ready_after", 64'(nm.in_ready), 1);
    chk("nm_out_valid_after", 64'(nm.out_valid), 0);

    // reset while waiting in RSP0, late response afterwards
    rsp_delay = 4;
    model(1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0);
    txn_id++;
    exp_active = 1'b1;
    accept(1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0, 0, acc);
    n = 0;
    while (beat_idx < 1 && n < 20) begin @(negedge clk); n++; end
    chk("rst_test_beat", 64'(beat_idx), 1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midrst", 64'(bus.in_ready), 1);
    repeat (5) @(negedge clk);
    chk("idle_after_late_rsp", 64'(bus.in_ready), 1);
    rsp_delay = 0;
    do_acc(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 0, 0, 3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
